multiplier_seq: RTL and testbench

//  Iterative shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU group.

---
 rtl/multiplier_seq_pkg.sv | 29 ++
 rtl/multiplier_seq.sv | 95 +++++++++
 tb/tb_multiplier_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_seq_pkg.sv
// multiplier_seq_pkg: shared encodings for the iterative RV32M multiplier
//   MUL_OP_*     operation encodings driven by the decoder on MULop
//   mul_state_t  FSM state encoding (MUL_STATE_IDLE/CALC/DONE)
//   op_rs1_signed / op_rs2_signed  operand signedness per operation
package multiplier_seq_pkg;

    localparam int MUL_OP_WIDTH = 3;

    localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MUL    = 3'd0;
    localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULH   = 3'd1;
    localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULHSU = 3'd2;
    localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULHU  = 3'd3;

    typedef enum logic [1:0] {
        MUL_STATE_IDLE = 2'd0,
        MUL_STATE_CALC = 2'd1,
        MUL_STATE_DONE = 2'd2
    } mul_state_t;

    // Unknown encodings fall through as unsigned, i.e. behave as MULHU
    function automatic logic op_rs1_signed(input logic [MUL_OP_WIDTH-1:0] op);
        return op == MUL_OP_MUL || op == MUL_OP_MULH || op == MUL_OP_MULHSU;
    endfunction

    function automatic logic op_rs2_signed(input logic [MUL_OP_WIDTH-1:0] op);
        return op == MUL_OP_MUL || op == MUL_OP_MULH;
    endfunction

endpackage

// File: rtl/multiplier_seq.sv
// multiplier_seq: iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   rs1        multiplicand (signed for MUL/MULH/MULHSU)
//   rs2        multiplier (signed for MUL/MULH)
//   MULop      operation select (MUL_OP_*)
//   mul_valid  request, held until mul_ready
//   rd         registered result, stable until the next accept
//   mul_ready  one-cycle strobe, rd valid this cycle
//   busy       high in CALC and DONE
module multiplier_seq
    import multiplier_seq_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [WIDTH-1:0]        rs1,
    input  logic [WIDTH-1:0]        rs2,
    input  logic [MUL_OP_WIDTH-1:0] MULop,
    input  logic                    mul_valid,
    output logic [WIDTH-1:0]        rd,
    output logic                    mul_ready,
    output logic                    busy
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    mul_state_t              state, state_next;
    logic [2*WIDTH-1:0]      acc, mcand, pp, acc_next, prod;
    logic [WIDTH-1:0]        mplier, abs1, abs2;
    logic [CNT_W-1:0]        cnt;
    logic [MUL_OP_WIDTH-1:0] op;
    logic                    neg, s1, s2;

    // Sign conditioning: magnitudes are iterated, sign is reapplied at the end
    always_comb begin
        s1   = op_rs1_signed(MULop) && rs1[WIDTH-1];
        s2   = op_rs2_signed(MULop) && rs2[WIDTH-1];
        abs1 = s1 ? -rs1 : rs1;
        abs2 = s2 ? -rs2 : rs2;
    end

    always_comb begin
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++)
            if (mplier[i]) pp = pp + (mcand << i);
        acc_next = acc + pp;
        prod     = neg ? -acc_next : acc_next;
    end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= MUL_STATE_IDLE;
        else         state <= state_next;

    always_comb
        state_next = (state == MUL_STATE_IDLE) ? (mul_valid ? MUL_STATE_CALC : MUL_STATE_IDLE) :
                     (state == MUL_STATE_CALC) ? ((cnt == '0) ? MUL_STATE_DONE : MUL_STATE_CALC) :
                                                 MUL_STATE_IDLE;

    always_comb begin
        mul_ready = state == MUL_STATE_DONE;
        busy      = state != MUL_STATE_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            op     <= '0;
            neg    <= 1'b0;
            rd     <= '0;
        end else if (state == MUL_STATE_IDLE && mul_valid) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, abs1};
            mplier <= abs2;
            cnt    <= CNT_W'(STEPS - 1);
            op     <= MULop;
            neg    <= s1 ^ s2;
        end else if (state == MUL_STATE_CALC) begin
            acc    <= acc_next;
            mcand  <= mcand << BITS_PER_CYCLE;
            mplier <= mplier >> BITS_PER_CYCLE;
            cnt    <= (cnt == '0) ? cnt : cnt - 1'b1;
            // Result lands on the CALC->DONE edge so it is valid alongside mul_ready
            if (cnt == '0)
                rd <= (op == MUL_OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: tb/tb_multiplier_seq.sv
// tb_multiplier_seq: self-checking bench for multiplier_seq (1 and 4 bits per cycle)
module tb_multiplier_seq;
    import multiplier_seq_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic [2:0]  mulop = '0;
    logic        valid1 = 1'b0, valid4 = 1'b0;
    logic [31:0] rd1, rd4;
    logic        ready1, ready4, busy1, busy4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiplier_seq #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .resetn(resetn), .rs1(rs1), .rs2(rs2), .MULop(mulop),
        .mul_valid(valid1), .rd(rd1), .mul_ready(ready1), .busy(busy1));

    multiplier_seq #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .resetn(resetn), .rs1(rs1), .rs2(rs2), .MULop(mulop),
        .mul_valid(valid4), .rd(rd4), .mul_ready(ready4), .busy(busy4));

    // Reference: exact 64-bit product of the operands as RV32M interprets them
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x, y, p;
        x = (o == 3'd0 || o == 3'd1 || o == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        y = (o == 3'd0 || o == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        p = x * y;
        return (o == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    // Issue one request; lat counts cycles from the accept edge to the strobe cycle
    task automatic do_op(input bit w4, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat, output bit one_cycle);
        @(negedge clk);
        rs1 = a; rs2 = b; mulop = o;
        if (w4) valid4 = 1'b1; else valid1 = 1'b1;
        @(posedge clk); #1;
        valid1 = 1'b0; valid4 = 1'b0;
        lat = 1;
        while (!(w4 ? ready4 : ready1) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        r = w4 ? rd4 : rd1;
        @(posedge clk); #1;
        one_cycle = !(w4 ? ready4 : ready1);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rd1 !== 32'd0 || ready1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut1: rd=%h ready=%b busy=%b, required rd=0 ready=0 busy=0", rd1, ready1, busy1);
        end
        checks++;
        if (rd4 !== 32'd0 || ready4 !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut4: rd=%h ready=%b busy=%b, required rd=0 ready=0 busy=0", rd4, ready4, busy4);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_directed;
        logic [2:0]  ops [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        logic [31:0] as  [5] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
        logic [31:0] bs  [5] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] exp [5] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0};
        logic [31:0] r;
        int lat;
        bit one;
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 5; i++) begin
                do_op(w[0], ops[i], as[i], bs[i], r, lat, one);
                checks++;
                if (r !== exp[i]) begin
                    errors++;
                    $display("FAIL directed_rd bpc=%0d #%0d: got %h, required %h", w ? 4 : 1, i, r, exp[i]);
                end
                checks++;
                if (lat != (w ? 9 : 33) || !one) begin
                    errors++;
                    $display("FAIL directed_timing bpc=%0d #%0d: latency %0d single=%0b, required %0d single=1",
                             w ? 4 : 1, i, lat, one, w ? 9 : 33);
                end
            end
    endtask

    task automatic test_unknown_op;
        logic [31:0] r;
        int lat;
        bit one;
        for (int o = 4; o < 8; o++) begin
            do_op(1'b0, 3'(o), 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, one);
            checks++;
            if (r !== 32'hFFFFFFFE) begin
                errors++;
                $display("FAIL unknown_op %0d: got %h, required fffffffe", o, r);
            end
        end
    endtask

    task automatic test_midcalc_change;
        int lat;
        logic [31:0] exp;
        exp = model(3'd1, 32'h12345678, 32'hF0000001);
        @(negedge clk);
        rs1 = 32'h12345678; rs2 = 32'hF0000001; mulop = 3'd1; valid1 = 1'b1;
        @(posedge clk); #1;
        valid1 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rs1 = 32'hDEADBEEF; rs2 = 32'h00000003; mulop = 3'd0;
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL midcalc_busy: got %b, required 1", busy1);
        end
        lat = 0;
        while (!ready1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (rd1 !== exp || !ready1) begin
            errors++;
            $display("FAIL midcalc_change: rd=%h ready=%b, required rd=%h ready=1", rd1, ready1, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midcalc;
        logic [31:0] r;
        int lat;
        bit one;
        do_op(1'b0, 3'd0, 32'd5, 32'd9, r, lat, one);
        @(negedge clk);
        rs1 = 32'd1000; rs2 = 32'd1000; mulop = 3'd0; valid1 = 1'b1;
        @(posedge clk); #1;
        valid1 = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b1 || rd1 !== 32'd45) begin
            errors++;
            $display("FAIL pre_abort: busy=%b rd=%h, required busy=1 rd=0000002d", busy1, rd1);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (rd1 !== 32'd0 || ready1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL abort: rd=%h ready=%b busy=%b, required rd=0 ready=0 busy=0", rd1, ready1, busy1);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (ready1) begin
                checks++;
                errors++;
                $display("FAIL abort_strobe: ready=1 during reset, required 0");
            end
        end
        @(negedge clk);
        resetn = 1'b1;
        do_op(1'b0, 3'd0, 32'd1000, 32'hFFFFFFFF, r, lat, one);
        checks++;
        if (r !== 32'hFFFFFC18 || lat != 33 || !one) begin
            errors++;
            $display("FAIL after_abort: rd=%h lat=%0d single=%0b, required rd=fffffc18 lat=33 single=1", r, lat, one);
        end
    endtask

    task automatic test_random;
        logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000001};
        logic [31:0] a, b, r, exp;
        logic [2:0] o;
        int lat;
        bit one;
        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            o = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            exp = model(o, a, b);
            do_op(i[0], o, a, b, r, lat, one);
            checks++;
            if (r !== exp || lat != (i[0] ? 9 : 33)) begin
                errors++;
                $display("FAIL random op=%0d a=%h b=%h bpc=%0d: rd=%h lat=%0d, required rd=%h lat=%0d",
                         o, a, b, i[0] ? 4 : 1, r, lat, exp, i[0] ? 9 : 33);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r [2];
        int t [2];
        int n, cyc;
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            rs1 = 32'hFFFFFFF0; rs2 = 32'd3; mulop = 3'd0;
            if (w == 1) valid4 = 1'b1; else valid1 = 1'b1;
            @(posedge clk); #1;
            rs1 = 32'h40000000; rs2 = 32'h00000010; mulop = 3'd3;
            n = 0;
            cyc = 1;
            while (n < 2 && cyc < 300) begin
                if (w == 1 ? ready4 : ready1) begin
                    r[n] = (w == 1) ? rd4 : rd1;
                    t[n] = cyc;
                    n++;
                    if (n == 2) begin valid1 = 1'b0; valid4 = 1'b0; end
                end
                @(posedge clk); #1;
                cyc++;
            end
            valid1 = 1'b0; valid4 = 1'b0;
            checks++;
            if (n != 2 || r[0] !== model(3'd0, 32'hFFFFFFF0, 32'd3) || r[1] !== model(3'd3, 32'h40000000, 32'h10)) begin
                errors++;
                $display("FAIL b2b_results bpc=%0d: strobes=%0d rd0=%h rd1=%h, required 2 strobes rd0=%h rd1=%h",
                         w ? 4 : 1, n, r[0], r[1], model(3'd0, 32'hFFFFFFF0, 32'd3), model(3'd3, 32'h40000000, 32'h10));
            end
            checks++;
            if (n != 2 || t[1] - t[0] != (w ? 10 : 34)) begin
                errors++;
                $display("FAIL b2b_spacing bpc=%0d: gap %0d, required %0d", w ? 4 : 1, t[1] - t[0], w ? 10 : 34);
            end
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if ((w == 1 ? busy4 : busy1) !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle bpc=%0d: busy=1, required 0", w ? 4 : 1);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_unknown_op;
        test_midcalc_change;
        test_reset_midcalc;
        test_random;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
